// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an 8-bit synchronous FIFO one byte at a time and sends
// each byte as an asynchronous serial frame. The frame is a start bit, 8 data
// bits LSB first, an optional parity bit, and one stop bit.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   fifo_empty_i  FIFO empty flag
//   fifo_rd_en_o  single-cycle FIFO pop strobe, only ever in idle
//   fifo_data_i   FIFO registered read data, valid the cycle after the pop
//   tx_o          serial line, registered, idle high
//   busy_o        high while a frame is being fetched or sent
//   frame_done_o  one-cycle pulse on the last cycle of the stop bit
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty_i,
  output logic       fifo_rd_en_o,
  input  logic [7:0] fifo_data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       frame_done_o
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end = (baud_q == BaudLast);

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    tx_d         = tx_q;
    fifo_rd_en_o = 1'b0;
    frame_done_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        baud_d    = '0;
        bit_idx_d = '0;
        tx_d      = 1'b1;
        // Gated by rst so a reset cycle never pops a byte that would be lost.
        if (!fifo_empty_i && !rst) begin
          fifo_rd_en_o = 1'b1;
          state_d      = StLoad;
        end
      end

      StLoad: begin
        // FIFO read data is valid this cycle (one after the pop).
        shift_d  = fifo_data_i;
        parity_d = (^fifo_data_i) ^ PARITY_ODD;
        tx_d     = 1'b0;
        baud_d   = '0;
        state_d  = StStart;
      end

      StStart: begin
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          state_d   = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      StData: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            if (PARITY_EN) begin
              tx_d    = parity_q;
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      StParity: begin
        if (bit_end) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = StStop;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      StStop: begin
        tx_d = 1'b1;
        if (bit_end) begin
          frame_done_o = 1'b1;
          baud_d       = '0;
          state_d      = StIdle;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx. It uses one 4-clock-per-bit
// instance without parity and two 2-clock-per-bit instances with even and odd
// parity. Each instance is fed from a small queue-based FIFO model whose read
// data is registered, so it appears the cycle after the pop.
module tb_fifo_uart_tx;

  localparam int NA = 4;
  localparam int NP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       empty_a, rd_a, tx_a, busy_a, done_a;
  logic [7:0] data_a;
  logic       empty_p;
  logic [7:0] data_p;
  logic       rd_pe, tx_pe, busy_pe, done_pe;
  logic       rd_po, tx_po, busy_po, done_po;

  logic [7:0] qa[$];
  logic [7:0] qp[$];

  int total;
  int bad;

  fifo_uart_tx #(.CLKS_PER_BIT(NA), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (empty_a),
    .fifo_rd_en_o (rd_a),
    .fifo_data_i  (data_a),
    .tx_o         (tx_a),
    .busy_o       (busy_a),
    .frame_done_o (done_a)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(NP), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut_pe (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (empty_p),
    .fifo_rd_en_o (rd_pe),
    .fifo_data_i  (data_p),
    .tx_o         (tx_pe),
    .busy_o       (busy_pe),
    .frame_done_o (done_pe)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(NP), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut_po (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (empty_p),
    .fifo_rd_en_o (rd_po),
    .fifo_data_i  (data_p),
    .tx_o         (tx_po),
    .busy_o       (busy_po),
    .frame_done_o (done_po)
  );

  // line[i] is the i-th bit on the wire: {stop, data[7:0], start}.
  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Advance one cycle. Returns at posedge+2 with FIFO model inputs settled.
  task automatic tick();
    logic ra, rp;
    @(negedge clk);
    ra = rd_a;
    rp = rd_pe;
    chk("rd_a_while_empty", {31'd0, ra & empty_a}, 32'd0);
    chk("rd_p_while_empty", {31'd0, rp & empty_p}, 32'd0);
    @(posedge clk);
    #1;
    if (ra && qa.size() > 0) data_a = qa.pop_front();
    if (rp && qp.size() > 0) data_p = qp.pop_front();
    empty_a = (qa.size() == 0);
    empty_p = (qp.size() == 0);
    #1;
  endtask

  task automatic push_a(input logic [7:0] b);
    qa.push_back(b);
    empty_a = 1'b0;
    #1;
  endtask

  task automatic push_p(input logic [7:0] b);
    qp.push_back(b);
    empty_p = 1'b0;
    #1;
  endtask

  task automatic wait_pop_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!ok) begin
        if (rd_a) ok = 1'b1;
        else tick();
      end
    end
    chk("pop_a_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_pop_p(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!ok) begin
        if (rd_pe) ok = 1'b1;
        else tick();
      end
    end
    chk("pop_p_timeout", {31'd0, ok}, 32'd1);
  endtask

  // Entered on the pop cycle; ends on the idle cycle after frame_done.
  task automatic frame_a(input logic [9:0] line, input string tag);
    tick();
    chk({tag, " load tx"}, {31'd0, tx_a}, 32'd1);
    chk({tag, " load busy"}, {31'd0, busy_a}, 32'd1);
    tick();
    for (int c = 0; c < 10 * NA; c++) begin
      chk($sformatf("%s tx c%0d", tag, c), {31'd0, tx_a}, {31'd0, line[c / NA]});
      chk($sformatf("%s done c%0d", tag, c), {31'd0, done_a}, {31'd0, c == 10 * NA - 1});
      chk($sformatf("%s rd c%0d", tag, c), {31'd0, rd_a}, 32'd0);
      chk($sformatf("%s busy c%0d", tag, c), {31'd0, busy_a}, 32'd1);
      tick();
    end
    chk({tag, " idle busy"}, {31'd0, busy_a}, 32'd0);
    chk({tag, " idle tx"}, {31'd0, tx_a}, 32'd1);
    chk({tag, " idle done"}, {31'd0, done_a}, 32'd0);
  endtask

  task automatic frame_p(input logic [10:0] le, input logic [10:0] lo, input string tag);
    chk({tag, " pop odd"}, {31'd0, rd_po}, 32'd1);
    tick();
    tick();
    for (int c = 0; c < 11 * NP; c++) begin
      chk($sformatf("%s even tx c%0d", tag, c), {31'd0, tx_pe}, {31'd0, le[c / NP]});
      chk($sformatf("%s odd tx c%0d", tag, c), {31'd0, tx_po}, {31'd0, lo[c / NP]});
      chk($sformatf("%s even done c%0d", tag, c), {31'd0, done_pe}, {31'd0, c == 11 * NP - 1});
      chk($sformatf("%s odd done c%0d", tag, c), {31'd0, done_po}, {31'd0, c == 11 * NP - 1});
      tick();
    end
    chk({tag, " even idle busy"}, {31'd0, busy_pe}, 32'd0);
    chk({tag, " odd idle busy"}, {31'd0, busy_po}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    empty_a = 1'b1;
    empty_p = 1'b1;
    data_a  = 8'h00;
    data_p  = 8'h00;

    vecs[0] = '{data: 8'h01, line: 10'b1_00000001_0};
    vecs[1] = '{data: 8'h80, line: 10'b1_10000000_0};
    vecs[2] = '{data: 8'h3C, line: 10'b1_00111100_0};
    vecs[3] = '{data: 8'hC3, line: 10'b1_11000011_0};

    repeat (2) @(posedge clk);
    #2;

    // Reset held with a non-empty FIFO: no pop, line idle.
    push_a(8'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst tx %0d", i), {31'd0, tx_a}, 32'd1);
      chk($sformatf("rst busy %0d", i), {31'd0, busy_a}, 32'd0);
      chk($sformatf("rst rd %0d", i), {31'd0, rd_a}, 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("first pop after rst", {31'd0, rd_a}, 32'd1);
    frame_a(10'b1_10100101_0, "a5");
    chk("a5 no second pop", {31'd0, rd_a}, 32'd0);

    // Table of single bytes.
    for (int i = 0; i < 4; i++) begin
      push_a(vecs[i].data);
      wait_pop_a(ok);
      if (ok) frame_a(vecs[i].line, $sformatf("vec%0d", i));
    end

    // Back-to-back: next pop falls on the idle cycle right after frame_done.
    push_a(8'h00);
    push_a(8'hFF);
    wait_pop_a(ok);
    if (ok) begin
      frame_a(10'b1_00000000_0, "b2b0");
      chk("b2b second pop", {31'd0, rd_a}, 32'd1);
      frame_a(10'b1_11111111_0, "b2b1");
      chk("b2b no third pop", {31'd0, rd_a}, 32'd0);
    end

    // Empty FIFO for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      tick();
      chk($sformatf("empty rd %0d", i), {31'd0, rd_a}, 32'd0);
      chk($sformatf("empty tx %0d", i), {31'd0, tx_a}, 32'd1);
      chk($sformatf("empty busy %0d", i), {31'd0, busy_a}, 32'd0);
    end

    // Parity: 0x07 has three ones, 0x00 has none. {stop, parity, data, start}.
    push_p(8'h07);
    wait_pop_p(ok);
    if (ok) frame_p(11'b1_1_00000111_0, 11'b1_0_00000111_0, "par07");
    push_p(8'h00);
    wait_pop_p(ok);
    if (ok) frame_p(11'b1_0_00000000_0, 11'b1_1_00000000_0, "par00");

    // Reset during data bit 3 of 0x5A (bit 3 spans frame cycles 16..19).
    push_a(8'h5A);
    wait_pop_a(ok);
    if (ok) begin
      tick();
      tick();
      repeat (17) tick();
      chk("mid bit3 tx", {31'd0, tx_a}, 32'd1);
      push_a(8'hC3);
      rst = 1'b1;
      #1;
      chk("mid rst rd", {31'd0, rd_a}, 32'd0);
      for (int i = 0; i < 2; i++) begin
        tick();
        chk($sformatf("mid rst tx %0d", i), {31'd0, tx_a}, 32'd1);
        chk($sformatf("mid rst busy %0d", i), {31'd0, busy_a}, 32'd0);
        chk($sformatf("mid rst rd %0d", i), {31'd0, rd_a}, 32'd0);
      end
      rst = 1'b0;
      #1;
      chk("post rst pop", {31'd0, rd_a}, 32'd1);
      frame_a(10'b1_11000011_0, "post_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
